// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the core's LSU/AMO side
// (master) and the memory responder (slave).
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. The master holds req_valid and all req_* fields
// stable until that edge and may not withdraw a request once raised.
// req_ready never depends on req_valid. resp_valid is a one-cycle strobe
// with no back-pressure; resp_rdata/resp_err are meaningful only while
// resp_valid is 1.
interface dmem_responder_if #(
    parameter int DATA_WIDTH = 32
) ();
    localparam int MASK_SIZE = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [MASK_SIZE-1:0]  req_mask;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_mask,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_mask,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one read or byte-masked write at a time,
// waits LATENCY cycles from acceptance and returns one response. Writes
// return the word's pre-write contents so read-modify-write sequences see
// consistent data. Out-of-range addresses respond with resp_err=1 and zero
// data, with the same timing as an in-range access.
module dmem_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int DMEM_SZ_IN_KB = 1,
    parameter int LATENCY       = 2
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    bus,
    output logic [1:0]         fsm_state
);
    localparam int MASK_SIZE = DATA_WIDTH / 8;
    localparam int DEPTH     = DMEM_SZ_IN_KB * 1024 / MASK_SIZE;
    localparam int OFS       = $clog2(MASK_SIZE);
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int CNT_W     = $clog2(LATENCY + 1);
    localparam logic [DATA_WIDTH:0] MEM_BYTES = (DATA_WIDTH + 1)'(DMEM_SZ_IN_KB * 1024);

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be >= 1");
        end
        if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
            $error("dmem_responder: DATA_WIDTH must be a multiple of 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  accept;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Ready is withheld during reset so a request coinciding with reset is
    // never accepted.
    assign bus.req_ready = (state == S_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign idx           = bus.req_addr[OFS+IDX_W-1:OFS];
    assign in_range      = {1'b0, bus.req_addr} < MEM_BYTES;
    assign fsm_state     = state;

    // Byte-masked array write on the accept edge; the array is never reset,
    // so a write accepted before a mid-operation reset stays committed.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && in_range) begin
            for (int i = 0; i < MASK_SIZE; i++) begin
                if (bus.req_mask[i]) begin
                    mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request FSM: latch old word at accept, count wait states, strobe the
    // response for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        bus.resp_rdata <= in_range ? mem[idx] : '0;
                        bus.resp_err   <= !in_range;
                        if (LATENCY == 1) begin
                            state          <= S_RESP;
                            bus.resp_valid <= 1'b1;
                        end else begin
                            cnt   <= CNT_W'(LATENCY - 1);
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt <= CNT_W'(1)) begin
                        cnt            <= '0;
                        state          <= S_RESP;
                        bus.resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
